// File: rtl/logic_shift_unit.sv
// logic_shift_unit: sequential bitwise logic / iterative shift-rotate unit with start/busy/done handshake.
// Optional rotates (ops 6, 7) enabled by defining LOGIC_SHIFT_ROTATE_EN.
module logic_shift_unit #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 67,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  result,
    output logic              carry,
    output logic              zero,
    output logic              err
);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t            r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_work;
    logic [SH_W-1:0]   r_cnt;
    logic              r_err;
    logic              r_carry;
    logic [DATA_W-1:0] w_logic;
    logic [DATA_W-1:0] w_next;
    logic              w_out;
    logic              w_shift;
    logic              w_legal;
    always_comb begin
        w_logic = op == 3'd0 ? a & b : op == 3'd1 ? a | b : a ^ b;
`ifdef LOGIC_SHIFT_ROTATE_EN
        w_shift = op >= 3'd3;
        w_legal = 1'b1;
        w_next  = r_op == 3'd3 ? {r_work[DATA_W-2:0], 1'b0} :
                  r_op == 3'd6 ? {r_work[DATA_W-2:0], r_work[DATA_W-1]} :
                  r_op == 3'd7 ? {r_work[0], r_work[DATA_W-1:1]} :
                  {r_op == 3'd5 & r_work[DATA_W-1], r_work[DATA_W-1:1]};
        w_out   = (r_op == 3'd3 || r_op == 3'd6) ? r_work[DATA_W-1] : r_work[0];
`else
        w_shift = op >= 3'd3 && op <= 3'd5;
        w_legal = op <= 3'd5;
        w_next  = r_op == 3'd3 ? {r_work[DATA_W-2:0], 1'b0} :
                  {r_op == 3'd5 & r_work[DATA_W-1], r_work[DATA_W-1:1]};
        w_out   = r_op == 3'd3 ? r_work[DATA_W-1] : r_work[0];
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_carry <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_op    <= op;
                    r_work  <= w_shift ? a : w_legal ? w_logic : '0;
                    r_cnt   <= w_shift ? b[SH_W-1:0] : '0;
                    r_err   <= !w_legal;
                    r_carry <= 1'b0;
                    busy    <= 1'b1;
                    r_state <= EXEC;
                end
            end else if (r_cnt != '0) begin
                r_work  <= w_next;
                r_carry <= w_out;
                r_cnt   <= r_cnt - 1'b1;
            end else begin
                result  <= OUT_W'(r_work);
                carry   <= r_carry;
                zero    <= r_work == '0;
                err     <= r_err;
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_logic_shift_unit.sv
// tb_logic_shift_unit: table vectors, corner sequences and random ops against an arithmetic reference model.
module tb_logic_shift_unit;
    localparam int W  = 32;
    localparam int OW = 67;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, carry, zero, err;
    logic [OW-1:0] result;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    logic_shift_unit #(.DATA_W(W), .OUT_W(OW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .err(err)
    );

    typedef struct {
        logic [2:0]    o;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [OW-1:0] r;
        logic          c;
        logic          z;
        logic          e;
        int            lat;
    } vec_t;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit rot_en();
`ifdef LOGIC_SHIFT_ROTATE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: whole-word arithmetic; latency counts shift steps as n
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c, output logic e, output int n);
        int s;
        s = int'(y[4:0]);
        r = '0; c = 1'b0; e = 1'b0; n = 0;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = x ^ y;
            3'd3: begin r = x << s; c = s != 0 && x[W-s]; n = s; end
            3'd4: begin r = x >> s; c = s != 0 && x[s-1]; n = s; end
            3'd5: begin r = $signed(x) >>> s; c = s != 0 && x[s-1]; n = s; end
            default: begin
                if (rot_en()) begin
                    n = s;
                    if (s == 0) r = x;
                    else if (o == 3'd6) begin r = (x << s) | (x >> (W - s)); c = r[0]; end
                    else begin r = (x >> s) | (x << (W - s)); c = r[W-1]; end
                end else e = 1'b1;
            end
        endcase
    endfunction

    // Called at a negedge; start is captured on the next posedge, returns at the done negedge
    task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int inj,
                       output logic [OW-1:0] res, output logic c, output logic z, output logic e,
                       output int cyc, output int bc);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        cyc = 1; bc = 0;
        while (!done && cyc < 100) begin
            if (busy) bc++;
            start = cyc == inj;
            if (cyc == inj) op = 3'd0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        res = result; c = carry; z = zero; e = err;
    endtask

    initial begin
        vec_t          tv[$];
        logic [OW-1:0] res;
        logic          c, z, e;
        logic [W-1:0]  mr;
        logic          mc, me;
        int            cyc, bc, n, extra;
        logic [2:0]    ro;
        logic [W-1:0]  rx, ry;

        tv.push_back('{3'd0, 32'h0000FFFF, 32'hFFFF0000, 67'h0, 1'b0, 1'b1, 1'b0, 2});
        tv.push_back('{3'd2, 32'h0000FFFF, 32'hFFFF8000, 67'h0_FFFF7FFF, 1'b0, 1'b0, 1'b0, 2});
        tv.push_back('{3'd1, 32'h0000FFFF, 32'hFFFF8000, 67'h0_FFFFFFFF, 1'b0, 1'b0, 1'b0, 2});
        tv.push_back('{3'd3, 32'hA5A5A5A5, 32'd1, 67'h4B4B4B4A, 1'b1, 1'b0, 1'b0, 3});
        tv.push_back('{3'd4, 32'hA5A5A5A5, 32'd4, 67'h0A5A5A5A, 1'b0, 1'b0, 1'b0, 6});
        tv.push_back('{3'd3, 32'h12345678, 32'hFFFFFFE0, 67'h12345678, 1'b0, 1'b0, 1'b0, 2});
        tv.push_back('{3'd3, 32'h00000003, 32'd31, 67'h80000000, 1'b1, 1'b0, 1'b0, 33});
        tv.push_back('{3'd5, 32'h7FFFFFF0, 32'd3, 67'h0FFFFFFE, 1'b0, 1'b0, 1'b0, 5});
`ifdef LOGIC_SHIFT_ROTATE_EN
        tv.push_back('{3'd6, 32'h80000001, 32'd4, 67'h00000018, 1'b0, 1'b0, 1'b0, 6});
        tv.push_back('{3'd7, 32'h80000001, 32'd4, 67'h18000000, 1'b0, 1'b0, 1'b0, 6});
`else
        tv.push_back('{3'd6, 32'h80000001, 32'd4, 67'h0, 1'b0, 1'b1, 1'b1, 2});
        tv.push_back('{3'd7, 32'h80000001, 32'd4, 67'h0, 1'b0, 1'b1, 1'b1, 2});
`endif

        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {carry, zero, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table entries are issued back-to-back, each in the previous done cycle
        foreach (tv[i]) begin
            run(tv[i].o, tv[i].x, tv[i].y, 0, res, c, z, e, cyc, bc);
            chk($sformatf("vec%0d_latency", i), cyc, tv[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bc, tv[i].lat - 1);
            chk($sformatf("vec%0d_result", i), res, tv[i].r);
            chk($sformatf("vec%0d_carry", i), c, tv[i].c);
            chk($sformatf("vec%0d_zero", i), z, tv[i].z);
            chk($sformatf("vec%0d_err", i), e, tv[i].e);
        end

        // SAR by 31 with an AND request injected mid-operation
        @(negedge clk);
        run(3'd5, 32'h80000000, 32'd31, 10, res, c, z, e, cyc, bc);
        chk("sar31_latency", cyc, 33);
        chk("sar31_busy_cycles", bc, 32);
        chk("sar31_result", res, 67'h0_FFFFFFFF);
        chk("sar31_carry", c, 0);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            extra += int'(done);
        end
        chk("sar31_single_done", extra, 0);
        chk("sar31_idle_busy", busy, 0);

        // Asynchronous reset in the middle of SHR by 20
        run(3'd4, 32'hFFFFFFFF, 32'd20, 5, res, c, z, e, cyc, bc);
        @(negedge clk);
        op = 3'd4; a = 32'hFFFFFFFF; b = 32'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_result", result, 0);
        chk("midreset_flags", {done, carry, zero, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            extra += int'(done) + int'(busy);
        end
        chk("midreset_no_done", extra, 0);
        run(3'd0, 32'hF0F0F0F0, 32'hF0F0F0F0, 0, res, c, z, e, cyc, bc);
        chk("post_reset_and", res, 67'h0_F0F0F0F0);
        chk("post_reset_latency", cyc, 2);

        // Random ops against the reference model
        for (int k = 0; k < 300; k++) begin
            ro = 3'($urandom);
            rx = $urandom;
            ry = $urandom;
            if (k % 4 == 0) ry[4:0] = 5'd0;
            model(ro, rx, ry, mr, mc, me, n);
            if (k % 3 == 0) @(negedge clk);
            run(ro, rx, ry, (k % 5 == 0) ? 1 : 0, res, c, z, e, cyc, bc);
            chk($sformatf("rnd%0d_op%0d_result", k, ro), res, {35'd0, mr});
            chk($sformatf("rnd%0d_op%0d_carry", k, ro), c, mc);
            chk($sformatf("rnd%0d_op%0d_zero", k, ro), z, mr == '0);
            chk($sformatf("rnd%0d_op%0d_err", k, ro), e, me);
            chk($sformatf("rnd%0d_op%0d_latency", k, ro), cyc, n + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/logic_shift_unit.md
Name: logic_shift_unit

Overview:
- Parametrised sequential successor to the combinational and/or/xor ops and the one-bit registered lshift/rshift.
- Executes one bitwise logic op or one multi-bit shift/rotate per request, behind a start/busy/done handshake.
- Shifts are iterative, one bit position per clock, so area stays small.
- Results are zero-extended to the ALU result-bus width and feed the LOGICop_UNIT result mux.

Parameters:
DATA_W, 32, operand width; power of 2, >= 8.
OUT_W, 67, result bus width; must be >= DATA_W.
SH_W, $clog2(DATA_W), shift-amount width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled only when busy=0
op  input  3  0 AND, 1 OR, 2 XOR, 3 SHL, 4 SHR (logical), 5 SAR (arithmetic), 6 ROL, 7 ROR
a  input  DATA_W  operand A; the value shifted for ops 3-7
b  input  DATA_W  operand B for logic ops; bits [SH_W-1:0] are the shift amount n for ops 3-7
busy  output  1  op in progress
done  output  1  one-cycle pulse: result, carry, zero and err valid
result  output  OUT_W  registered result; bits [OUT_W-1:DATA_W] always 0
carry  output  1  last bit shifted or rotated out; 0 for logic ops and n=0
zero  output  1  result[DATA_W-1:0]==0; qualified by done
err  output  1  illegal opcode; qualified by done

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0; state=IDLE; internal work register and counter cleared.
  - Any in-flight op is discarded with no done pulse.
- State IDLE:
  - start=1 at edge k: capture op, a, b[SH_W-1:0].
  - Logic op: work = a op b, cnt = 0.
  - Shift/rotate: work = a, cnt = n.
  - Illegal op: work = 0, err flag set, cnt = 0.
  - Go to EXEC; busy=1 after edge k.
- State EXEC, each edge:
  - cnt != 0: shift work by one position and decrement cnt. carry captures the bit leaving (SHL: bit DATA_W-1; SHR/SAR: bit 0; ROL/ROR: the bit that wraps).
  - Fill bits: SHL/SHR fill 0; SAR replicates bit DATA_W-1.
  - cnt == 0: result = zero-extended work; set zero and err; done=1; busy=0; return to IDLE.
- Latency:
  - done is high for exactly one cycle after edge k+1+n (n=0 for logic ops, illegal ops, and shifts by 0).
  - A shift by n keeps busy high for n+1 cycles.
- Shift by 0: result = a, carry = 0, same latency as a logic op.
- start while busy=1: ignored; the in-flight op is not disturbed and the request is not queued.
- start in the same cycle done=1: accepted, because the state is IDLE. This gives back-to-back ops with no bubble.
- result, carry, zero and err hold their values until the next done. done is the only pulse output.
- op, a and b may change freely after the start edge; only the captured copies are used.

Optional Feature:
- Macro: LOGIC_SHIFT_ROTATE_EN.
- Defined: ops 6 (ROL) and 7 (ROR) are legal and rotate work circularly one bit per cycle.
- Undefined: ops 6 and 7 are illegal and no rotate logic is synthesised. They finish with 1-edge latency, result=0, carry=0, zero=1, err=1.
- Ops 0-5 behave identically in both builds.

Test Plan:
- AND a=0x0000FFFF, b=0xFFFF0000 -> done one edge after start; result=0, zero=1, carry=0, err=0.
- XOR a=0x0000FFFF, b=0xFFFF8000 -> result=67'h0_FFFF7FFF, zero=0. Immediately issue OR (same a, b) in the done cycle -> result=0xFFFFFFFF on the next done, with no idle cycle between ops.
- SHL a=0xA5A5A5A5, n=1 -> done after 2 edges, result=0x4B4B4B4A, carry=1. SHR same a, n=4 -> done after 5 edges, result=0x0A5A5A5A, carry=0.
- SAR a=0x80000000, n=31 -> busy high for 32 cycles, result=0xFFFFFFFF, carry=0. A start pulse with op=AND mid-operation is ignored: exactly one done.
- ROL a=0x80000001, n=4 -> with LOGIC_SHIFT_ROTATE_EN: result=0x00000018, err=0. Without it: result=0, err=1, done after 1 edge.
- SHR a=0xFFFFFFFF, n=20; assert rst_n=0 after 5 cycles -> all outputs 0 immediately and no done. After release, AND a=b=0xF0F0F0F0 -> result=0xF0F0F0F0.
